// File: rtl/bka_pkg.sv
// Shared types and the prefix (black-cell) operator for the Brent-Kung adder.
package bka_pkg;

    localparam int BKA_WIDTH  = 32;
    localparam int BKA_LEVELS = $clog2(BKA_WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bka_prefix_tree.sv
// Combinational Brent-Kung prefix tree, split into up-sweep and down-sweep ports
// so the parent can optionally register the (G,P) vector between the two halves.
module bka_prefix_tree
    import bka_pkg::*;
#(
    parameter int WIDTH = BKA_WIDTH
) (
    input  gp_t              gp_i   [WIDTH],
    output gp_t              up_o   [WIDTH],
    input  gp_t              down_i [WIDTH],
    output logic [WIDTH-1:0] g_o
);

    localparam int LEVELS = $clog2(WIDTH);

    gp_t up_s [LEVELS+1][WIDTH];
    gp_t dn_s [1:LEVELS][WIDTH];
    // Group-propagate leaving the last level has no consumer.
    logic [WIDTH-1:0] unused_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_io
        assign up_s[0][i]      = gp_i[i];
        assign up_o[i]         = up_s[LEVELS][i];
        assign dn_s[LEVELS][i] = down_i[i];
        assign g_o[i]          = dn_s[1][i].g;
        assign unused_p[i]     = dn_s[1][i].p;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (1 << k)) == 0) begin : g_cell
                assign up_s[k][i] = gp_combine(up_s[k-1][i], up_s[k-1][i-(1<<(k-1))]);
            end else begin : g_pass
                assign up_s[k][i] = up_s[k-1][i];
            end
        end
    end

    // Down-sweep fills the odd-multiple positions from the nearest completed prefix below.
    for (genvar k = LEVELS - 1; k >= 1; k--) begin : g_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= (1 << k)) && (((i + 1) % (1 << k)) == (1 << (k - 1)))) begin : g_cell
                assign dn_s[k][i] = gp_combine(dn_s[k+1][i], dn_s[k+1][i-(1<<(k-1))]);
            end else begin : g_pass
                assign dn_s[k][i] = dn_s[k+1][i];
            end
        end
    end

endmodule

// File: rtl/brent_kung_adder_32.sv
// Registered Brent-Kung adder: sum/cout = a + b + cin. Define BKA_PIPE_EN to add a
// register stage between up-sweep and down-sweep (latency 2 instead of 1).
module brent_kung_adder_32
    import bka_pkg::*;
#(
    parameter int WIDTH = BKA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    gp_t              pre_gp  [WIDTH];
    gp_t              up_gp   [WIDTH];
    gp_t              down_gp [WIDTH];
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] stage_p;
    logic             stage_cin;
    logic             stage_valid;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pre_gp[i].g = a[i] & b[i];
            pre_gp[i].p = a[i] ^ b[i];
        end
        pre_gp[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    end

    bka_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .gp_i   (pre_gp),
        .up_o   (up_gp),
        .down_i (down_gp),
        .g_o    (grp_g)
    );

`ifdef BKA_PIPE_EN
    logic [WIDTH-1:0] pipe_grp_g_d, pipe_grp_g_q;
    logic [WIDTH-1:0] pipe_grp_p_d, pipe_grp_p_q;
    logic [WIDTH-1:0] pipe_p_d,     pipe_p_q;
    logic             pipe_cin_d,   pipe_cin_q;
    logic             pipe_valid_d, pipe_valid_q;

    always_comb begin
        pipe_grp_g_d = pipe_grp_g_q;
        pipe_grp_p_d = pipe_grp_p_q;
        pipe_p_d     = pipe_p_q;
        pipe_cin_d   = pipe_cin_q;
        pipe_valid_d = in_valid;
        if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                pipe_grp_g_d[i] = up_gp[i].g;
                pipe_grp_p_d[i] = up_gp[i].p;
                pipe_p_d[i]     = pre_gp[i].p;
            end
            pipe_cin_d = cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_grp_g_q <= '0;
            pipe_grp_p_q <= '0;
            pipe_p_q     <= '0;
            pipe_cin_q   <= 1'b0;
            pipe_valid_q <= 1'b0;
        end else begin
            pipe_grp_g_q <= pipe_grp_g_d;
            pipe_grp_p_q <= pipe_grp_p_d;
            pipe_p_q     <= pipe_p_d;
            pipe_cin_q   <= pipe_cin_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            down_gp[i].g = pipe_grp_g_q[i];
            down_gp[i].p = pipe_grp_p_q[i];
        end
        stage_p     = pipe_p_q;
        stage_cin   = pipe_cin_q;
        stage_valid = pipe_valid_q;
    end
`else
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            down_gp[i] = up_gp[i];
        end
        stage_p     = a ^ b;
        stage_cin   = cin;
        stage_valid = in_valid;
    end
`endif

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

    // NOTE: hold values are assigned first so every path drives sum_d/cout_d and no latch is inferred.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = stage_valid;
        if (stage_valid) begin
            sum_d  = stage_p ^ {grp_g[WIDTH-2:0], stage_cin};
            cout_d = grp_g[WIDTH-1];
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_brent_kung_adder_32.sv
// Scoreboard bench for brent_kung_adder_32; honours BKA_PIPE_EN for the expected latency.
module tb_brent_kung_adder_32;

`ifdef BKA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        out_valid;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_sum = '0;
    logic        last_cout = 1'b0;

    brent_kung_adder_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dc);
        logic [32:0] full;
        exp_t e;
        @(negedge clk);
        a = da; b = db; cin = dc; in_valid = 1'b1;
        full  = {1'b0, da} + {1'b0, db} + {32'd0, dc};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.due  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("latency", 64'(cyc), 64'(e.due));
                    last_sum  = e.sum;
                    last_cout = e.cout;
                end
            end else begin
                check("hold_sum", 64'(sum), 64'(last_sum));
                check("hold_cout", 64'(cout), 64'(last_cout));
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    check("missing_out_valid", 64'(out_valid), 64'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'd5, 32'd7, 1'b0);
        drive(32'd1, 32'd2, 1'b0);
        drive(32'd2, 32'd3, 1'b0);
        drive(32'd3, 32'd4, 1'b0);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        repeat (5) idle();

        for (int i = 0; i < 1000; i++) begin
            drive($urandom, $urandom, 1'($urandom));
        end
        repeat (5) idle();

        for (int i = 0; i < 20; i++) begin
            drive($urandom, $urandom, 1'($urandom));
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_sum", 64'(sum), 64'd0);
        check("midreset_cout", 64'(cout), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        last_sum  = '0;
        last_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'd10, 32'd20, 1'b0);
        repeat (4) idle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
